// File: rtl/display_sequencer.sv
// Display sequencer: alternates the display register between calculation results and a RAM scan.
// Optional continuous scanning is enabled by defining DISPLAY_SEQ_AUTO_WRAP_EN.
module display_sequencer #(
  parameter int unsigned DATADEPTH    = 16,
  parameter int unsigned ADDRWIDTH    = $clog2(DATADEPTH),
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cal_valid,
  input  logic                 scan_start,
  input  logic                 scan_stop,
  output logic                 cal_en,
  output logic                 read_en,
  output logic                 ram_rd_en,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic                 busy,
  output logic                 scan_done
);

  localparam int unsigned CntW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CntW-1:0]      CntInit  = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0]      CntOne   = CntW'(1);
  localparam logic [ADDRWIDTH-1:0] LastAddr = ADDRWIDTH'(DATADEPTH - 1);
  localparam logic [ADDRWIDTH-1:0] AddrOne  = ADDRWIDTH'(1);

  typedef enum logic [2:0] {
    StIdle,
    StCalShow,
    StRdAddr,
    StRdWait,
    StHold
  } state_e;

  state_e                state_q, state_d;
  logic [ADDRWIDTH-1:0]  addr_q, addr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  done_d;
  logic                  cal_en_q, read_en_q, ram_rd_en_q, busy_q, scan_done_q;
  logic                  scanning;

  assign scanning = (state_q == StRdAddr) || (state_q == StRdWait) || (state_q == StHold);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (cal_valid) begin
      // A new result always wins and discards any scan in progress.
      state_d = StCalShow;
      addr_d  = '0;
      cnt_d   = '0;
    end else if (scan_stop && scanning) begin
      state_d = StIdle;
      addr_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (scan_start) begin
            state_d = StRdAddr;
            addr_d  = '0;
          end
        end
        StCalShow: state_d = StIdle;
        StRdAddr:  state_d = StRdWait;
        StRdWait: begin
          state_d = StHold;
          cnt_d   = CntInit;
        end
        StHold: begin
          if (cnt_q == '0) begin
            if (addr_q == LastAddr) begin
              done_d = 1'b1;
              addr_d = '0;
`ifdef DISPLAY_SEQ_AUTO_WRAP_EN
              state_d = StRdAddr;
`else
              state_d = StIdle;
`endif
            end else begin
              addr_d  = addr_q + AddrOne;
              state_d = StRdAddr;
            end
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      cal_en_q    <= 1'b0;
      read_en_q   <= 1'b0;
      ram_rd_en_q <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      cal_en_q    <= (state_d == StCalShow);
      read_en_q   <= (state_d == StRdWait);
      ram_rd_en_q <= (state_d == StRdAddr);
      busy_q      <= (state_d != StIdle);
      scan_done_q <= done_d;
    end
  end

  assign cal_en    = cal_en_q;
  assign read_en   = read_en_q;
  assign ram_rd_en = ram_rd_en_q;
  assign ram_addr  = addr_q;
  assign busy      = busy_q;
  assign scan_done = scan_done_q;

  a_sel_exclusive: assert property (@(posedge clk) disable iff (rst) !(cal_en && read_en));
  a_read_after_rd: assert property (@(posedge clk) disable iff (rst) read_en |-> $past(ram_rd_en));
  a_addr_range:    assert property (@(posedge clk) disable iff (rst) ram_addr <= LastAddr);

endmodule

// File: tb/tb_display_sequencer.sv
// Randomized bench for display_sequencer, checked against a scan-position reference model.
// Define DISPLAY_SEQ_AUTO_WRAP_EN for both bench and RTL to exercise continuous scanning.
module tb_display_sequencer;

  localparam int unsigned DD = 4;
  localparam int unsigned DW = 3;
  localparam int unsigned AW = $clog2(DD);
  localparam int          P  = 2 + DW;     // cycles per word
  localparam int          NT = DD * P;     // cycles of one full pass

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cal_valid = 1'b0;
  logic          scan_start = 1'b0;
  logic          scan_stop = 1'b0;
  logic          cal_en, read_en, ram_rd_en, busy, scan_done;
  logic [AW-1:0] ram_addr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: m_t is the position within a scan pass (0 = not scanning).
  bit m_cal  = 1'b0;
  int m_t    = 0;
  bit m_done = 1'b0;

  display_sequencer #(
    .DATADEPTH   (DD),
    .DWELL_CYCLES(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cal_valid (cal_valid),
    .scan_start(scan_start),
    .scan_stop (scan_stop),
    .cal_en    (cal_en),
    .read_en   (read_en),
    .ram_rd_en (ram_rd_en),
    .ram_addr  (ram_addr),
    .busy      (busy),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input bit c, input bit sp, input bit st, input bit r);
    bit idle;
    idle = !m_cal && (m_t == 0);
    m_done = 1'b0;
    if (r) begin
      m_cal = 1'b0;
      m_t   = 0;
    end else if (c) begin
      m_cal = 1'b1;
      m_t   = 0;
    end else if (sp && m_t > 0) begin
      m_cal = 1'b0;
      m_t   = 0;
    end else if (idle) begin
      if (st) m_t = 1;
    end else if (m_cal) begin
      m_cal = 1'b0;
    end else if (m_t == NT) begin
      m_done = 1'b1;
`ifdef DISPLAY_SEQ_AUTO_WRAP_EN
      m_t = 1;
`else
      m_t = 0;
`endif
    end else begin
      m_t++;
    end
  endtask

  task automatic compare_all();
    int off;
    off = (m_t > 0) ? (m_t - 1) % P : -1;
    check("cal_en",    int'(cal_en),    int'(m_cal));
    check("ram_rd_en", int'(ram_rd_en), int'(off == 0));
    check("read_en",   int'(read_en),   int'(off == 1));
    check("ram_addr",  int'(ram_addr),  (m_t > 0) ? (m_t - 1) / P : 0);
    check("busy",      int'(busy),      int'(m_cal || m_t > 0));
    check("scan_done", int'(scan_done), int'(m_done));
  endtask

  // Apply one cycle of inputs, advance model and DUT, then compare away from the edge.
  task automatic cycle(input bit c, input bit sp, input bit st, input bit r);
    cal_valid  = c;
    scan_stop  = sp;
    scan_start = st;
    rst        = r;
    @(posedge clk);
    model_step(c, sp, st, r);
    #1;
    compare_all();
  endtask

  initial begin
    int done_at;
    #1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Full scan latency: scan_done is expected NT+1 cycles after the start cycle.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    done_at = -1;
    for (int k = 1; k <= 30; k++) begin
      if (scan_done && done_at < 0) done_at = k;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("done_latency", done_at, NT + 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset held two cycles in the middle of a scan.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (11) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Result arriving together with a scan request in idle.
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Result preempting a scan during a dwell, then back-to-back results.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (7) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 29) == 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
